// File: rtl/frame_capture.sv
// rtl/frame_capture.sv - PDET-triggered serial frame capture with XOR checksum
module frame_capture #(
  parameter int PAYLOAD_BYTES = 2
) (
  input  logic       CLK,
  input  logic       SCLR,
  input  logic       IN_DATA,
  input  logic       PDET,
  output logic [7:0] DOUT,
  output logic       DVALID,
  output logic       FRAME_DONE,
  output logic       FRAME_OK,
  output logic       FRAME_ERR,
  output logic [7:0] FRAME_CNT,
  output logic       BUSY
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    CHKSUM  = 2'd2
  } state_t;

  // Index of the final payload byte; byte_cnt is wide enough for 15 bytes
  // and only reaches PAYLOAD_BYTES after the last one, so it never wraps.
  localparam logic [3:0] LAST_BYTE = 4'(PAYLOAD_BYTES - 1);

  state_t     state;
  state_t     state_nxt;
  logic [2:0] bit_cnt;
  logic [3:0] byte_cnt;
  logic [6:0] shift_reg;
  logic [7:0] chk_acc;
  logic [7:0] byte_now;
  logic       byte_end;
  logic       start;
  logic       payload_byte;
  logic       chk_byte;

  // The byte completing this cycle: seven earlier bits plus the current one,
  // MSB first.
  assign byte_now = {shift_reg, IN_DATA};
  assign byte_end = (bit_cnt == 3'd7);
  assign BUSY     = (state != IDLE);

  // State register
  always_ff @(posedge CLK) begin
    if (SCLR) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and datapath strobes; PDET only matters in IDLE
  always_comb begin
    state_nxt    = state;
    start        = 1'b0;
    payload_byte = 1'b0;
    chk_byte     = 1'b0;
    case (state)
      IDLE: begin
        if (PDET) begin
          state_nxt = PAYLOAD;
          start     = 1'b1;
        end
      end
      PAYLOAD: begin
        if (byte_end) begin
          payload_byte = 1'b1;
          if (byte_cnt == LAST_BYTE) begin
            state_nxt = CHKSUM;
          end
        end
      end
      CHKSUM: begin
        if (byte_end) begin
          chk_byte  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Bit/byte counting, byte assembly, checksum and registered outputs
  always_ff @(posedge CLK) begin
    if (SCLR) begin
      bit_cnt    <= 3'd0;
      byte_cnt   <= 4'd0;
      shift_reg  <= 7'd0;
      chk_acc    <= 8'd0;
      DOUT       <= 8'd0;
      DVALID     <= 1'b0;
      FRAME_DONE <= 1'b0;
      FRAME_OK   <= 1'b0;
      FRAME_ERR  <= 1'b0;
      FRAME_CNT  <= 8'd0;
    end else begin
      DVALID     <= 1'b0;
      FRAME_DONE <= 1'b0;
      FRAME_OK   <= 1'b0;
      FRAME_ERR  <= 1'b0;
      if (start) begin
        // The edge that sees PDET also captures frame bit 0.
        shift_reg <= {6'd0, IN_DATA};
        bit_cnt   <= 3'd1;
        byte_cnt  <= 4'd0;
        chk_acc   <= 8'd0;
      end else if (state != IDLE) begin
        shift_reg <= byte_now[6:0];
        bit_cnt   <= bit_cnt + 3'd1;
        if (payload_byte) begin
          DOUT     <= byte_now;
          DVALID   <= 1'b1;
          chk_acc  <= chk_acc ^ byte_now;
          byte_cnt <= byte_cnt + 4'd1;
        end
        if (chk_byte) begin
          FRAME_DONE <= 1'b1;
          if (byte_now == chk_acc) begin
            FRAME_OK <= 1'b1;
            if (FRAME_CNT != 8'hFF) begin
              FRAME_CNT <= FRAME_CNT + 8'd1;
            end
          end else begin
            FRAME_ERR <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_frame_capture.sv
// tb/tb_frame_capture.sv - scoreboard bench for frame_capture
module tb_frame_capture;

  localparam int P = 2;

  logic       CLK;
  logic       SCLR;
  logic       IN_DATA;
  logic       PDET;
  logic [7:0] DOUT;
  logic       DVALID;
  logic       FRAME_DONE;
  logic       FRAME_OK;
  logic       FRAME_ERR;
  logic [7:0] FRAME_CNT;
  logic       BUSY;

  frame_capture #(.PAYLOAD_BYTES(P)) dut (
    .CLK        (CLK),
    .SCLR       (SCLR),
    .IN_DATA    (IN_DATA),
    .PDET       (PDET),
    .DOUT       (DOUT),
    .DVALID     (DVALID),
    .FRAME_DONE (FRAME_DONE),
    .FRAME_OK   (FRAME_OK),
    .FRAME_ERR  (FRAME_ERR),
    .FRAME_CNT  (FRAME_CNT),
    .BUSY       (BUSY)
  );

  typedef struct {
    int         cyc;
    logic [7:0] val;
  } byte_ev_t;

  typedef struct {
    int cyc;
    bit ok;
    int cnt;
  } done_ev_t;

  byte_ev_t   byte_q[$];
  done_ev_t   done_q[$];
  int         checks = 0;
  int         passes = 0;
  int         cyc_cnt = 0;
  int         good_cnt = 0;
  logic [7:0] fb [0:P];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Edge counter: after edge n, cyc_cnt == n
  always @(posedge CLK) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at edge %0d",
                  name, act, act, exp, exp, cyc_cnt);
  endtask

  // Monitor: compare DUT pulses with the scoreboard queues
  always @(negedge CLK) begin
    if (DVALID === 1'b1) begin
      if (byte_q.size() == 0) begin
        check("dvalid_unexpected", 1, 0);
      end else begin
        byte_ev_t e;
        e = byte_q.pop_front();
        check("dout_value", int'(DOUT), int'(e.val));
        check("dvalid_edge", cyc_cnt, e.cyc);
      end
    end
    if (FRAME_DONE === 1'b1) begin
      if (done_q.size() == 0) begin
        check("frame_done_unexpected", 1, 0);
      end else begin
        done_ev_t d;
        d = done_q.pop_front();
        check("frame_done_edge", cyc_cnt, d.cyc);
        check("frame_ok_err", int'({FRAME_OK, FRAME_ERR}), d.ok ? 2 : 1);
        check("frame_cnt", int'(FRAME_CNT), d.cnt);
      end
    end else if (FRAME_OK === 1'b1 || FRAME_ERR === 1'b1) begin
      check("ok_err_without_done", 1, 0);
    end
  end

  task automatic check_reset_state();
    check("rst_dout", int'(DOUT), 0);
    check("rst_dvalid", int'(DVALID), 0);
    check("rst_done", int'(FRAME_DONE), 0);
    check("rst_ok", int'(FRAME_OK), 0);
    check("rst_err", int'(FRAME_ERR), 0);
    check("rst_cnt", int'(FRAME_CNT), 0);
    check("rst_busy", int'(BUSY), 0);
  endtask

  task automatic do_reset();
    SCLR = 1'b1;
    PDET = 1'b0;
    @(posedge CLK); #1;
    SCLR = 1'b0;
    good_cnt = 0;
    check_reset_state();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      PDET    = 1'b0;
      IN_DATA = 1'($urandom);
      @(posedge CLK); #1;
    end
  endtask

  // Drive one frame from fb[]; abort_bit >= 0 asserts SCLR instead of that bit.
  task automatic send_frame(input int abort_bit, input bit noise);
    int         k;
    int         nbits;
    logic [7:0] x;
    logic [7:0] cur;
    bit         ok;
    nbits = 8 * (P + 1);
    x = 8'd0;
    for (int j = 0; j < P; j++) x ^= fb[j];
    ok = (fb[P] == x);
    k = cyc_cnt + 1;
    for (int j = 0; j < P; j++) begin
      if (abort_bit < 0 || 8 * j + 7 < abort_bit) begin
        byte_ev_t e;
        e.cyc = k + 8 * j + 7;
        e.val = fb[j];
        byte_q.push_back(e);
      end
    end
    if (abort_bit < 0) begin
      done_ev_t d;
      if (ok && good_cnt < 255) good_cnt++;
      d.cyc = k + nbits - 1;
      d.ok  = ok;
      d.cnt = good_cnt;
      done_q.push_back(d);
    end
    for (int i = 0; i < nbits; i++) begin
      if (i == abort_bit) begin
        check("busy_mid_frame", int'(BUSY), 1);
        SCLR = 1'b1;
        PDET = 1'b1;
        IN_DATA = 1'($urandom);
        @(posedge CLK); #1;
        SCLR = 1'b0;
        PDET = 1'b0;
        good_cnt = 0;
        check_reset_state();
        return;
      end
      cur     = fb[i / 8];
      IN_DATA = cur[7 - (i % 8)];
      PDET    = (i == 0) ? 1'b1 : (noise ? 1'($urandom) : 1'b0);
      @(posedge CLK); #1;
    end
    PDET = 1'b0;
  endtask

  task automatic set_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    fb[0] = a;
    fb[1] = b;
    fb[2] = c;
  endtask

  initial begin
    SCLR = 1'b1;
    PDET = 1'b0;
    IN_DATA = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    SCLR = 1'b0;
    check_reset_state();
    idle(3);

    set_frame(8'hA5, 8'h3C, 8'h99);
    send_frame(-1, 1'b0);
    idle(2);
    set_frame(8'hA5, 8'h3C, 8'h98);
    send_frame(-1, 1'b0);
    idle(2);
    set_frame(8'hAA, 8'hAA, 8'h00);
    send_frame(-1, 1'b1);
    idle(2);
    set_frame(8'h11, 8'h22, 8'h33);
    send_frame(10, 1'b0);
    idle(4);
    send_frame(-1, 1'b0);
    set_frame(8'h01, 8'h02, 8'h03);
    send_frame(-1, 1'b0);
    set_frame(8'hF0, 8'h0F, 8'hFF);
    send_frame(-1, 1'b0);
    idle(3);

    for (int n = 0; n < 40; n++) begin
      logic [7:0] x;
      x = 8'd0;
      for (int j = 0; j < P; j++) begin
        fb[j] = 8'($urandom);
        x ^= fb[j];
      end
      fb[P] = ($urandom_range(0, 2) == 0) ? (x ^ (8'd1 << $urandom_range(0, 7))) : x;
      send_frame(($urandom_range(0, 9) == 0) ? $urandom_range(1, 8 * (P + 1) - 1) : -1,
                 1'($urandom));
      idle($urandom_range(0, 3));
    end

    do_reset();
    for (int n = 0; n < 257; n++) begin
      fb[0] = 8'($urandom);
      fb[1] = 8'($urandom);
      fb[2] = fb[0] ^ fb[1];
      send_frame(-1, 1'($urandom));
    end
    idle(3);
    check("cnt_saturated", int'(FRAME_CNT), 255);
    check("byte_q_drained", byte_q.size(), 0);
    check("done_q_drained", done_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
